// File: rtl/lisnoc_traffic_node_if.sv
// One direction of a lisnoc local link: a shared flit bus with a valid/ready pair per VC.
interface lisnoc_traffic_node_if #(
  parameter int flit_width = 34,
  parameter int vchannels  = 4
);
  // A flit moves on VC v in every cycle where valid[v] && ready[v] is high.
  // The master holds flit and valid stable until that cycle; ready may change freely.
  logic [flit_width-1:0] flit;
  logic [vchannels-1:0]  valid;
  logic [vchannels-1:0]  ready;

  modport master (output flit, output valid, input ready);
  modport slave  (input flit, input valid, output ready);
endinterface

// File: rtl/lisnoc_traffic_node.sv
// Per-node traffic generator and sink for lisnoc mesh measurement runs.
// Injects fixed-length stamped packets and accumulates latency/error statistics on receive.
module lisnoc_traffic_node #(
  parameter int          flit_data_width = 32,
  parameter int          flit_type_width = 2,
  parameter int          vchannels       = 4,
  parameter int          nodes           = 16,
  parameter int          node_id         = 0,
  parameter int          packet_length   = 4,
  parameter int          num_packets     = 10000,
  parameter int          rate_width      = 16,
  parameter logic [31:0] lfsr_seed       = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [rate_width-1:0] rate,
  input  logic [vchannels-1:0]  vc_mask,
  lisnoc_traffic_node_if.master out_link,
  lisnoc_traffic_node_if.slave  in_link,
  output logic [31:0]           sent_count,
  output logic [31:0]           recv_count,
  output logic [47:0]           lat_sum,
  output logic [31:0]           lat_max,
  output logic [15:0]           err_count,
  output logic                  done,
  output logic [1:0]            gen_state
);

  localparam int dest_width = (nodes > 1) ? $clog2(nodes) : 1;
  localparam int vc_width   = (vchannels > 1) ? $clog2(vchannels) : 1;
  localparam logic [flit_type_width-1:0] type_payload = flit_type_width'(0);
  localparam logic [flit_type_width-1:0] type_header  = flit_type_width'(1);
  localparam logic [flit_type_width-1:0] type_last    = flit_type_width'(2);

  typedef enum logic [1:0] {GEN_IDLE = 2'd0, GEN_SEND = 2'd1, GEN_DONE = 2'd2} gen_state_t;
  typedef enum logic [1:0] {EXP_HDR = 2'd0, EXP_STAMP = 2'd1, EXP_BODY = 2'd2} sink_state_t;

  logic [31:0] lfsr;
  logic [31:0] cycle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr  <= lfsr_seed;
      cycle <= '0;
    end else begin
      lfsr  <= lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
      cycle <= cycle + 32'd1;
    end
  end

  // ---------------- generator ----------------
  gen_state_t            state_q, state_d;
  logic [dest_width-1:0] dest_q, dest_d, dest_pick;
  logic [vc_width-1:0]   vc_q, vc_d, last_vc_q, last_vc_d, vc_next, vc_cand;
  logic [31:0]           stamp_q, stamp_d, sent_d;
  logic [15:0]           idx_q, idx_d, dest_mod;
  logic                  vc_found, launch, fire, flit_last;
  logic [vchannels-1:0]  gen_valid;
  logic [flit_type_width-1:0] gen_type;
  logic [flit_data_width-1:0] gen_data;

  // Round robin starts one past the last VC used.
  always_comb begin
    vc_next  = last_vc_q;
    vc_cand  = '0;
    vc_found = 1'b0;
    for (int i = 1; i <= vchannels; i++) begin
      vc_cand = vc_width'((int'(last_vc_q) + i) % vchannels);
      if (!vc_found && vc_mask[vc_cand]) begin
        vc_found = 1'b1;
        vc_next  = vc_cand;
      end
    end
  end

  // Never address ourselves: a hit on node_id is bumped to the next node.
  always_comb begin
    dest_mod  = lfsr[31:16] % 16'(nodes);
    dest_pick = dest_width'(dest_mod);
    if (dest_mod == 16'(node_id))
      dest_pick = dest_width'((dest_mod + 16'd1) % 16'(nodes));
  end

  assign launch    = enable && (|vc_mask) && vc_found && (lfsr[rate_width-1:0] < rate);
  assign flit_last = (idx_q == 16'(packet_length - 1));
  assign fire      = gen_valid[vc_q] && out_link.ready[vc_q];

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    vc_d      = vc_q;
    last_vc_d = last_vc_q;
    stamp_d   = stamp_q;
    idx_d     = idx_q;
    sent_d    = sent_count;
    case (state_q)
      GEN_IDLE: begin
        if (launch) begin
          state_d   = GEN_SEND;
          dest_d    = dest_pick;
          vc_d      = vc_next;
          last_vc_d = vc_next;
          stamp_d   = cycle;
          idx_d     = '0;
        end
      end
      GEN_SEND: begin
        if (fire) begin
          if (flit_last) begin
            sent_d  = sent_count + 32'd1;
            state_d = (sent_d == 32'(num_packets)) ? GEN_DONE : GEN_IDLE;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
      end
      default: state_d = GEN_DONE;
    endcase
  end

  always_comb begin
    gen_valid = '0;
    gen_type  = type_payload;
    gen_data  = '0;
    if (state_q == GEN_SEND) begin
      gen_valid[vc_q] = 1'b1;
      if (idx_q == 16'd0) begin
        gen_type = type_header;
        gen_data[flit_data_width-1 -: dest_width] = dest_q;
        gen_data[dest_width-1:0] = dest_width'(node_id);
      end else if (idx_q == 16'd1) begin
        gen_data = flit_data_width'(stamp_q);
      end else begin
        gen_data = flit_data_width'(sent_count);
      end
      if (flit_last)
        gen_type = type_last;
    end
  end

  // last_vc resets to the top VC so the first packet searches from VC0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= GEN_IDLE;
      dest_q     <= '0;
      vc_q       <= '0;
      last_vc_q  <= vc_width'(vchannels - 1);
      stamp_q    <= '0;
      idx_q      <= '0;
      sent_count <= '0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      vc_q       <= vc_d;
      last_vc_q  <= last_vc_d;
      stamp_q    <= stamp_d;
      idx_q      <= idx_d;
      sent_count <= sent_d;
    end
  end

  assign out_link.valid = gen_valid;
  assign out_link.flit  = {gen_type, gen_data};
  assign done           = (state_q == GEN_DONE);
  assign gen_state      = state_q;

  // ---------------- sink ----------------
  sink_state_t                 sink_q [vchannels];
  logic [31:0]                 lat_cap_q [vchannels];
  sink_state_t                 sink_next;
  logic [vc_width-1:0]         in_vc;
  logic                        in_one, in_multi;
  logic                        rx_err, rx_commit, rx_capture;
  logic [flit_type_width-1:0]  rx_type;
  logic [flit_data_width-1:0]  rx_data;
  logic                        rx_to_us;
  logic [31:0]                 rx_lat, commit_lat;
  logic [48:0]                 sum_wide;

  assign in_link.ready = '1;
  assign in_one   = $onehot(in_link.valid);
  assign in_multi = (in_link.valid != '0) && !in_one;
  assign rx_type  = in_link.flit[flit_type_width+flit_data_width-1 -: flit_type_width];
  assign rx_data  = in_link.flit[flit_data_width-1:0];
  assign rx_to_us = (rx_data[flit_data_width-1 -: dest_width] == dest_width'(node_id));
  assign rx_lat   = cycle - 32'(rx_data);

  always_comb begin
    in_vc = '0;
    for (int i = 0; i < vchannels; i++)
      if (in_link.valid[i]) in_vc = vc_width'(i);
  end

  always_comb begin
    sink_next  = sink_q[in_vc];
    rx_err     = 1'b0;
    rx_commit  = 1'b0;
    rx_capture = 1'b0;
    commit_lat = lat_cap_q[in_vc];
    if (in_multi) begin
      rx_err = 1'b1;
    end else if (in_one) begin
      case (sink_q[in_vc])
        EXP_HDR: begin
          if (rx_type == type_header && rx_to_us) sink_next = EXP_STAMP;
          else rx_err = 1'b1;
        end
        EXP_STAMP: begin
          rx_capture = 1'b1;
          commit_lat = rx_lat;
          if (rx_type == type_last) begin
            rx_commit = 1'b1;
            sink_next = EXP_HDR;
          end else begin
            sink_next = EXP_BODY;
          end
        end
        EXP_BODY: begin
          if (rx_type == type_last) begin
            rx_commit = 1'b1;
            sink_next = EXP_HDR;
          end else if (rx_type == type_header) begin
            // A stray header aborts the packet and is taken as the start of a new one.
            rx_err    = 1'b1;
            sink_next = rx_to_us ? EXP_STAMP : EXP_HDR;
          end else if (rx_type != type_payload) begin
            rx_err    = 1'b1;
            sink_next = EXP_HDR;
          end
        end
        default: sink_next = EXP_HDR;
      endcase
    end
  end

  assign sum_wide = {1'b0, lat_sum} + 49'(commit_lat);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < vchannels; i++) begin
        sink_q[i]    <= EXP_HDR;
        lat_cap_q[i] <= '0;
      end
      recv_count <= '0;
      lat_sum    <= '0;
      lat_max    <= '0;
      err_count  <= '0;
    end else begin
      if (in_one) begin
        sink_q[in_vc] <= sink_next;
        if (rx_capture) lat_cap_q[in_vc] <= rx_lat;
      end
      if (rx_err && err_count != 16'hFFFF)
        err_count <= err_count + 16'd1;
      if (rx_commit) begin
        recv_count <= recv_count + 32'd1;
        lat_sum    <= sum_wide[48] ? '1 : sum_wide[47:0];
        if (commit_lat > lat_max) lat_max <= commit_lat;
      end
    end
  end

endmodule

// File: tb/tb_lisnoc_traffic_node.sv
// Directed bench for lisnoc_traffic_node: generator packets checked through an expected-flit queue,
// sink statistics checked against counters kept by the bench.
module tb_lisnoc_traffic_node;
  localparam int vch = 4;
  localparam int fw  = 34;
  localparam logic [1:0] t_pay  = 2'b00;
  localparam logic [1:0] t_hdr  = 2'b01;
  localparam logic [1:0] t_last = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] rate;
  logic [3:0]  vc_mask;
  logic [31:0] sent_count, recv_count, lat_max;
  logic [47:0] lat_sum;
  logic [15:0] err_count;
  logic        done;
  logic [1:0]  gen_state;

  lisnoc_traffic_node_if #(.flit_width(fw), .vchannels(vch)) out_link ();
  lisnoc_traffic_node_if #(.flit_width(fw), .vchannels(vch)) in_link ();

  lisnoc_traffic_node #(
    .node_id(5), .packet_length(4), .num_packets(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .rate(rate), .vc_mask(vc_mask),
    .out_link(out_link), .in_link(in_link),
    .sent_count(sent_count), .recv_count(recv_count), .lat_sum(lat_sum),
    .lat_max(lat_max), .err_count(err_count), .done(done), .gen_state(gen_state)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference cycle counter and LFSR; *_d hold the previous cycle's values.
  logic [31:0] m_lfsr, m_lfsr_d, m_cycle, m_cycle_d;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr <= 32'hACE1_0001; m_lfsr_d <= 32'hACE1_0001;
      m_cycle <= '0; m_cycle_d <= '0;
    end else begin
      m_lfsr_d  <= m_lfsr;
      m_cycle_d <= m_cycle;
      m_lfsr    <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
      m_cycle   <= m_cycle + 32'd1;
    end
  end

  logic [fw-1:0] exp_q[$];
  bit          pkt_active, period_chk, have_prev;
  int          mon_idx, exp_vc, exp_last_vc, flits_seen, valid_cycles;
  logic [31:0] exp_sent, prev_hdr_cycle;

  // Called on the first valid cycle of a packet; the decision cycle was the one before.
  task automatic start_packet();
    logic [3:0] d;
    bit f;
    int c;
    f = 0;
    for (int i = 1; i <= vch; i++) begin
      c = (exp_last_vc + i) % vch;
      if (!f && vc_mask[c]) begin f = 1; exp_vc = c; end
    end
    exp_last_vc = exp_vc;
    d = 4'(m_lfsr_d[31:16] % 16);
    if (d == 4'd5) d = 4'd6;
    exp_q.push_back({t_hdr, d, 24'h0, 4'd5});
    exp_q.push_back({t_pay, m_cycle_d});
    exp_q.push_back({t_pay, exp_sent});
    exp_q.push_back({t_last, 32'h0});
    if (period_chk && have_prev) check("packet_period", 64'(m_cycle - prev_hdr_cycle), 64'd5);
    prev_hdr_cycle = m_cycle;
    have_prev  = 1;
    pkt_active = 1;
    mon_idx    = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (out_link.valid != '0) begin
        valid_cycles++;
        if (!pkt_active) start_packet();
        check("out_valid_vc", 64'(out_link.valid), 64'(4'b1 << exp_vc));
        if (exp_q.size() == 0) begin
          check("exp_q_size", 64'(exp_q.size()), 64'd1);
        end else begin
          if (mon_idx == 3) check("flit_last_type", 64'(out_link.flit[33:32]), 64'(exp_q[0][33:32]));
          else check("flit", 64'(out_link.flit), 64'(exp_q[0]));
          if ((out_link.valid & out_link.ready) != '0) begin
            void'(exp_q.pop_front());
            flits_seen++;
            if (mon_idx == 3) begin pkt_active = 0; mon_idx = 0; exp_sent++; end
            else mon_idx++;
          end
        end
      end else if (pkt_active) begin
        check("valid_held_midpacket", 64'(out_link.valid), 64'(4'b1 << exp_vc));
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    pkt_active = 0; mon_idx = 0; exp_last_vc = vch - 1; exp_vc = 0;
    exp_sent = 0; flits_seen = 0; valid_cycles = 0; have_prev = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    out_link.ready = 4'hF; in_link.valid = '0; in_link.flit = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [1:0] t, input logic [31:0] d);
    in_link.valid = v;
    in_link.flit  = {t, d};
    @(posedge clk); #1;
    in_link.valid = '0;
    in_link.flit  = '0;
  endtask

  function automatic logic [31:0] hdr(input logic [3:0] dst, input logic [3:0] src);
    return {dst, 24'h0, src};
  endfunction

  int          e_recv, e_err;
  logic [47:0] e_sum;
  logic [31:0] e_max;

  task automatic expect_commit(input logic [31:0] lat);
    e_recv++;
    e_sum = e_sum + 48'(lat);
    if (lat > e_max) e_max = lat;
  endtask

  task automatic check_sink(input string tag);
    check({tag, "_recv"},    64'(recv_count), 64'(e_recv));
    check({tag, "_lat_sum"}, 64'(lat_sum),    64'(e_sum));
    check({tag, "_lat_max"}, 64'(lat_max),    64'(e_max));
    check({tag, "_err"},     64'(err_count),  64'(e_err));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0; enable = 1'b0; rate = '0; vc_mask = 4'b0101;
    out_link.ready = 4'hF; in_link.valid = '0; in_link.flit = '0;
    period_chk = 0; clear_model();
    e_recv = 0; e_err = 0; e_sum = '0; e_max = '0;
    #12;
    check("rst_out_valid",  64'(out_link.valid), 64'd0);
    check("rst_out_flit",   64'(out_link.flit),  64'd0);
    check("rst_in_ready",   64'(in_link.ready),  64'hF);
    check("rst_sent",       64'(sent_count),     64'd0);
    check("rst_recv",       64'(recv_count),     64'd0);
    check("rst_lat_sum",    64'(lat_sum),        64'd0);
    check("rst_lat_max",    64'(lat_max),        64'd0);
    check("rst_err",        64'(err_count),      64'd0);
    check("rst_done",       64'(done),           64'd0);
    check("rst_gen_state",  64'(gen_state),      64'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // rate 0: nothing may be injected
    enable = 1'b1; rate = 16'h0000;
    repeat (1000) @(posedge clk);
    #1;
    check("rate0_valid_cycles", 64'(valid_cycles), 64'd0);
    check("rate0_sent",         64'(sent_count),   64'd0);

    // full rate: three packets alternating VC0/VC2, then done
    rate = 16'hFFFF; period_chk = 1;
    n = 0;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    check("done_reached",   64'(done),         64'd1);
    check("done_sent",      64'(sent_count),   64'(exp_sent));
    check("done_packets",   64'(exp_sent),     64'd3);
    check("done_flits",     64'(flits_seen),   64'd12);
    n = valid_cycles;
    repeat (20) @(posedge clk);
    #1;
    check("done_quiet",     64'(valid_cycles - n), 64'd0);
    check("done_hold",      64'(done),         64'd1);
    check("done_gen_state", 64'(gen_state),    64'd2);
    period_chk = 0;

    // stall mid-packet for 10 cycles
    apply_reset();
    n = 0;
    while (!(pkt_active && mon_idx == 2) && n < 50) begin @(posedge clk); #1; n++; end
    check("stall_reached", 64'(mon_idx), 64'd2);
    out_link.ready = 4'hF & ~(4'b1 << exp_vc);
    repeat (10) @(posedge clk);
    #1;
    check("stall_no_progress", 64'(flits_seen), 64'd2);
    check("stall_sent",        64'(sent_count), 64'd0);
    out_link.ready = 4'hF;
    n = 0;
    while (exp_sent != 1 && n < 50) begin @(posedge clk); #1; n++; end
    check("stall_resume_sent",  64'(sent_count), 64'd1);
    check("stall_resume_flits", 64'(flits_seen), 64'd4);

    // asynchronous reset in the middle of the next packet
    n = 0;
    while (!(pkt_active && mon_idx == 1) && n < 50) begin @(posedge clk); #1; n++; end
    check("midrst_reached", 64'(mon_idx), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(out_link.valid), 64'd0);
    check("midrst_flit",  64'(out_link.flit),  64'd0);
    check("midrst_sent",  64'(sent_count),     64'd0);
    check("midrst_done",  64'(done),           64'd0);
    enable = 1'b0; rate = 16'h0000;
    apply_reset();

    // sink: single packet on VC1, latency 60
    drive(4'b0010, t_hdr, hdr(4'd5, 4'd2));
    drive(4'b0010, t_pay, m_cycle - 32'd60);
    repeat (3) @(posedge clk);
    #1;
    drive(4'b0010, t_pay, 32'h1234);
    drive(4'b0010, t_last, 32'h0);
    expect_commit(32'd60);
    check_sink("vc1_pkt");

    // interleaved VC0/VC3 with one multi-valid cycle dropped
    drive(4'b0001, t_hdr, hdr(4'd5, 4'd1));
    drive(4'b1000, t_hdr, hdr(4'd5, 4'd9));
    drive(4'b0001, t_pay, m_cycle - 32'd30);
    drive(4'b1000, t_pay, m_cycle - 32'd90);
    drive(4'b0011, t_hdr, hdr(4'd5, 4'd1));
    e_err++;
    drive(4'b0001, t_pay, 32'hABCD);
    drive(4'b1000, t_last, 32'h0);
    expect_commit(32'd90);
    drive(4'b0001, t_last, 32'h0);
    expect_commit(32'd30);
    check_sink("interleave");

    // wrong destination and non-header while expecting a header
    drive(4'b0100, t_hdr, hdr(4'd7, 4'd1));
    e_err++;
    drive(4'b0100, t_pay, 32'h0);
    e_err++;
    check_sink("bad_hdr");

    // two-flit packet: stamp flit is LAST
    drive(4'b0100, t_hdr, hdr(4'd5, 4'd3));
    drive(4'b0100, t_last, m_cycle - 32'd5);
    expect_commit(32'd5);
    check_sink("short_pkt");

    // header inside a body restarts the packet
    drive(4'b0010, t_hdr, hdr(4'd5, 4'd3));
    drive(4'b0010, t_pay, m_cycle - 32'd10);
    drive(4'b0010, t_hdr, hdr(4'd5, 4'd3));
    e_err++;
    drive(4'b0010, t_last, m_cycle - 32'd200);
    expect_commit(32'd200);
    check_sink("hdr_in_body");

    // stamp ahead of the cycle counter: latency wraps modulo 2^32
    drive(4'b0001, t_hdr, hdr(4'd5, 4'd4));
    drive(4'b0001, t_pay, m_cycle - 32'hFFFF_FFF0);
    drive(4'b0001, t_last, 32'h0);
    expect_commit(32'hFFFF_FFF0);
    check_sink("lat_wrap");
    check("sink_in_ready", 64'(in_link.ready), 64'hF);
    check("sink_no_inject", 64'(sent_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
